// File: rtl/gps_sched_pkg.sv
// Shared definitions for the GPS service-request scheduler.
//   state_t  : scheduler FSM states (IDLE, BUSY)
//   GID_W    : width of a grant / requester index
//   host_idx : request index used by the host for a given channel count
package gps_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned GID_W = 4;

  // The host request sits directly above the last demodulator channel.
  function automatic logic [GID_W-1:0] host_idx(input int unsigned n_chans);
    return n_chans[GID_W-1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i    : candidate request vector (N bits)
//   last_i   : index granted most recently
//   winner_o : first set request searching upward from last_i+1, wrapping modulo N
//   any_o    : at least one request is set
module rr_pick
  import gps_sched_pkg::*;
#(
  parameter int unsigned N = 13
) (
  input  logic [N-1:0]     req_i,
  input  logic [GID_W-1:0] last_i,
  output logic [GID_W-1:0] winner_o,
  output logic             any_o
);

  logic             found;
  logic [GID_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = GID_W'((32'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/gps_srq_sched.sv
// GPS service-request scheduler: latches per-channel epoch pulses and a host
// request, grants them one at a time round-robin, and aborts a grant that is
// not serviced within TIMEOUT cycles.
//   clk, rst_n   : clock, asynchronous active-low reset
//   chan_srq     : per-channel epoch pulses
//   host_srq     : host request pulse (index V_GPS_CHANS)
//   chan_mask    : per-channel enable
//   svc_done     : host finished with the current grant
//   flag_clr     : clears sticky overrun / timeout
//   grant_valid  : grant outstanding
//   grant_id     : granted index
//   pending      : latched unserviced requests
//   overrun      : sticky per-index overrun
//   timeout      : sticky watchdog abort
module gps_srq_sched
  import gps_sched_pkg::*;
#(
  parameter int unsigned V_GPS_CHANS = 12,
  parameter logic [15:0] TIMEOUT     = 16'd49152
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [V_GPS_CHANS-1:0] chan_srq,
  input  logic                   host_srq,
  input  logic [V_GPS_CHANS-1:0] chan_mask,
  input  logic                   svc_done,
  input  logic                   flag_clr,
  output logic                   grant_valid,
  output logic [GID_W-1:0]       grant_id,
  output logic [V_GPS_CHANS:0]   pending,
  output logic [V_GPS_CHANS:0]   overrun,
  output logic                   timeout
);

  localparam int unsigned      NREQ = V_GPS_CHANS + 1;
  localparam logic [GID_W-1:0] HOST = host_idx(V_GPS_CHANS);

  state_t             state_q;
  logic [GID_W-1:0]   grant_id_q;
  logic [GID_W-1:0]   last_q;
  logic [15:0]        wd_q;
  logic [NREQ-1:0]    pending_q, pending_d;
  logic [NREQ-1:0]    overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    en_mask;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    grant_clr;
  logic [GID_W-1:0]   win;
  logic               win_any;
  logic               grant_go;
  logic               done_go;
  logic               expire;

  assign req      = {host_srq, chan_srq & chan_mask};
  assign en_mask  = {1'b1, chan_mask};
  // A channel masked this cycle loses its pending bit on the coming edge, so it
  // must not be picked on that same edge either.
  assign eligible = pending_q & en_mask;

  rr_pick #(.N(NREQ)) u_pick (
    .req_i    (eligible),
    .last_i   (last_q),
    .winner_o (win),
    .any_o    (win_any)
  );

  always_comb begin
    grant_go  = (state_q == IDLE) && win_any;
    done_go   = (state_q == BUSY) && svc_done;
    // svc_done in the expiry cycle counts as completion, not abort.
    expire    = (state_q == BUSY) && !svc_done && (wd_q == TIMEOUT - 16'd1);
    grant_clr = '0;
    if (grant_go) grant_clr[win] = 1'b1;
    // A new request on the index being granted re-sets its pending bit.
    pending_d = ((pending_q & ~grant_clr) | req) & en_mask;
    overrun_d = (overrun_q & {NREQ{~flag_clr}}) | (req & pending_q);
    timeout_d = (timeout_q & ~flag_clr) | expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_q     <= HOST;
      wd_q       <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      case (state_q)
        IDLE: begin
          if (grant_go) begin
            state_q    <= BUSY;
            grant_id_q <= win;
            wd_q       <= '0;
          end
        end
        BUSY: begin
          wd_q <= wd_q + 16'd1;
          if (done_go || expire) begin
            state_q <= IDLE;
            last_q  <= grant_id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule
